sum_unmask_decoder: RTL and testbench

//  Receive side of the masked-adder link. The transmitter sends sum = a + b + ~di (mod 2^W).
//  di is a W-bit phase register: it starts at all-zeros and inverts once per transferred beat.
//  The mask ~di is therefore all-ones on phase 0 and all-zeros on phase 1.

---
 rtl/sum_unmask_decoder_pkg.sv | 26 ++
 rtl/sum_unmask_decoder_fifo2.sv | 58 +++++
 rtl/sum_unmask_decoder.sv | 101 ++++++++++
 tb/tb_sum_unmask_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_unmask_decoder_pkg.sv
// Shared types and the unmask helper for the masked-adder link receiver.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// Contents: state_t (decoder FSM states), PH_MASKED (phase whose mask is
// all-ones), unmask() (recovers b from a and the masked sum).
package sum_unmask_pkg;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        RUN       = 1'b1
    } state_t;

    // Phase in which the transmitter adds an all-ones mask (i.e. subtracts 1).
    localparam logic PH_MASKED = 1'b0;

    // sum = a + b + mask, with mask = -1 in the masked phase and 0 otherwise,
    // so b = sum - a + 1 or b = sum - a. Evaluated at 32 bits; the caller
    // truncates to its data width, which keeps the result correct mod 2^W.
    function automatic logic [31:0] unmask(input logic [31:0] a,
                                           input logic [31:0] sum,
                                           input logic        phase);
        unmask = sum - a + ((phase == PH_MASKED) ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/sum_unmask_decoder_fifo2.sv
// Two-entry FIFO with occupancy count; output holds last popped word when empty.
// Latency: a word pushed into an empty FIFO is visible on o_dat the next cycle.
// Backpressure: pushes are ignored when full, pops ignored when empty; caller gates with o_cnt.
//
// Ports: clk/rst_n (sync active-low), i_push/i_dat write side, i_pop read side,
// o_dat head word (or last popped word when empty), o_vld non-empty, o_cnt occupancy 0..2.
module fifo2 #(
    parameter int DW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_dat,
    input  logic          i_pop,
    output logic [DW-1:0] o_dat,
    output logic          o_vld,
    output logic [1:0]    o_cnt
);

    logic [DW-1:0] r_mem [0:1];
    logic [DW-1:0] r_last;
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_cnt;

    logic w_push;
    logic w_pop;

    assign w_push = i_push && (r_cnt != 2'd2);
    assign w_pop  = i_pop  && (r_cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_last   <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_dat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                // Remember the word leaving so the output holds it once empty.
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_dat = (r_cnt == 2'd0) ? r_last : r_mem[r_rd_ptr];
    assign o_vld = (r_cnt != 2'd0);
    assign o_cnt = r_cnt;

endmodule

// File: rtl/sum_unmask_decoder.sv
// Masked-adder link receiver: tracks the transmitter phase and recovers b = f(a, sum, phase).
// Latency: accepted beat appears on out_b the next cycle when the buffer is empty.
// Backpressure: 2-entry buffer; in_ready drops at 2 entries, from registered state only.
//
// Ports: clk, rst_n (sync active-low); sync_i phase realign; in_valid/in_ready/in_a/in_sum
// input stream; out_valid/out_ready/out_b/out_phase output stream; beat_cnt accepted beats.
module sum_unmask_decoder
    import sum_unmask_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_b,
    output logic             out_phase,
    output logic [CNT_W-1:0] beat_cnt
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_phase;
    logic              w_phase_nxt;
    logic [CNT_W-1:0]  r_beat_cnt;

    logic              w_accept;
    logic              w_eff_phase;
    logic [W-1:0]      w_b;
    logic [W:0]        w_head;
    logic [1:0]        w_cnt;

    // A sync in the same cycle as a beat realigns that very beat to the masked phase.
    assign w_eff_phase = sync_i ? PH_MASKED : r_phase;
    assign w_accept    = in_valid && in_ready;
    assign w_b         = W'(unmask(32'(in_a), 32'(in_sum), w_eff_phase));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= WAIT_SYNC;
            r_phase    <= PH_MASKED;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        in_ready    = 1'b0;
        case (r_state)
            WAIT_SYNC: begin
                // Phase is parked at the masked phase until the link is aligned.
                w_phase_nxt = PH_MASKED;
                if (sync_i) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                in_ready = (w_cnt < 2'd2);
                if (w_accept) begin
                    w_phase_nxt = ~w_eff_phase;
                end else if (sync_i) begin
                    w_phase_nxt = PH_MASKED;
                end
            end
            default: begin
                w_state_nxt = WAIT_SYNC;
            end
        endcase
    end

    fifo2 #(
        .DW (W + 1)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_accept),
        .i_dat  ({w_eff_phase, w_b}),
        .i_pop  (out_ready),
        .o_dat  (w_head),
        .o_vld  (out_valid),
        .o_cnt  (w_cnt)
    );

    assign out_b     = w_head[W-1:0];
    assign out_phase = w_head[W];
    assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_sum_unmask_decoder.sv
module tb_sum_unmask_decoder;

    logic       clk;
    logic       rst_n;
    logic       sync_i;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_sum;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_b;
    logic       out_phase;
    logic [7:0] beat_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: link state, phase, queue of {phase, b}, last popped word, counter.
    bit         m_run;
    bit         m_phase;
    logic [4:0] m_q[$];
    logic [4:0] m_last;
    logic [7:0] m_cnt;

    sum_unmask_decoder #(.W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_i    (sync_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_phase (out_phase),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter relation: sum = a + b + mask, mask = 15 in phase 0, 0 in phase 1.
    function automatic logic [3:0] ref_b(input logic [3:0] a, input logic [3:0] sum, input bit ph);
        int mask;
        mask = ph ? 0 : 15;
        return 4'((int'(sum) - int'(a) - mask + 32) % 16);
    endfunction

    function automatic bit m_ready();
        return m_run && (m_q.size() < 2);
    endfunction

    function automatic logic [4:0] exp_head();
        return (m_q.size() > 0) ? m_q[0] : m_last;
    endfunction

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic cycle();
        bit acc, pop, eff;
        if (!rst_n) begin
            m_run = 0; m_phase = 0; m_q.delete(); m_last = '0; m_cnt = '0;
        end else begin
            acc = in_valid && m_ready();
            pop = (m_q.size() > 0) && out_ready;
            eff = sync_i ? 1'b0 : m_phase;
            if (!m_run) begin
                if (sync_i) begin m_run = 1; m_phase = 0; end
            end else if (acc) begin
                m_phase = ~eff;
            end else if (sync_i) begin
                m_phase = 0;
            end
            if (pop) begin m_last = m_q[0]; void'(m_q.pop_front()); end
            if (acc) begin m_q.push_back({eff, ref_b(in_a, in_sum, eff)}); m_cnt = m_cnt + 8'd1; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; sync_i = 0; in_valid = 0; out_ready = 0; in_a = 0; in_sum = 0;
        cycle(); cycle();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_checks++; if (out_b !== 4'd0 || out_phase !== 1'b0) begin n_fails++; $display("FAIL reset_out got=%0d/%b want=0/0", out_b, out_phase); end
        in_valid = 1; in_a = 4'd3; in_sum = 4'd4; out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL nosync_in_ready cyc=%0d got=%b want=0", i, in_ready); end
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL nosync_out_valid got=%b want=0", out_valid); end
        n_checks++; if (beat_cnt !== 8'd0) begin n_fails++; $display("FAIL nosync_beat_cnt got=%0d want=0", beat_cnt); end
        in_valid = 0;
    endtask

    task automatic test_basic_decode();
        sync_i = 1; cycle(); sync_i = 0;
        n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL run_in_ready got=%b want=1", in_ready); end
        out_ready = 1; in_valid = 1; in_a = 4'd3; in_sum = 4'd4;
        cycle();
        n_checks++; if (out_valid !== 1'b1 || out_b !== 4'd2 || out_phase !== 1'b0) begin
            n_fails++; $display("FAIL basic_beat0 got v=%b b=%0d ph=%b want v=1 b=2 ph=0", out_valid, out_b, out_phase); end
        in_sum = 4'd5;
        cycle();
        n_checks++; if (out_valid !== 1'b1 || out_b !== 4'd2 || out_phase !== 1'b1) begin
            n_fails++; $display("FAIL basic_beat1 got v=%b b=%0d ph=%b want v=1 b=2 ph=1", out_valid, out_b, out_phase); end
        in_valid = 0;
        cycle();
        n_checks++; if (out_valid !== 1'b0 || out_b !== 4'd2) begin
            n_fails++; $display("FAIL empty_hold got v=%b b=%0d want v=0 b=2", out_valid, out_b); end
        n_checks++; if (beat_cnt !== 8'd2) begin n_fails++; $display("FAIL basic_cnt got=%0d want=2", beat_cnt); end
    endtask

    task automatic test_wrap();
        in_valid = 1; in_a = 4'd15; in_sum = 4'd0;
        cycle();
        n_checks++; if (out_b !== 4'd2 || out_phase !== 1'b0) begin
            n_fails++; $display("FAIL wrap_ph0 got b=%0d ph=%b want b=2 ph=0", out_b, out_phase); end
        in_sum = 4'd1;
        cycle();
        n_checks++; if (out_b !== 4'd2 || out_phase !== 1'b1) begin
            n_fails++; $display("FAIL wrap_ph1 got b=%0d ph=%b want b=2 ph=1", out_b, out_phase); end
        in_valid = 0;
        cycle();
    endtask

    task automatic test_backpressure();
        logic [3:0] held_b;
        logic       held_ph;
        logic [4:0] first;
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            in_a = 4'($urandom_range(0, 15)); in_sum = 4'($urandom_range(0, 15));
            cycle();
        end
        n_checks++; if (m_q.size() != 2) begin n_fails++; $display("FAIL bp_model_depth got=%0d want=2", m_q.size()); end
        n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        n_checks++; if (beat_cnt !== m_cnt) begin n_fails++; $display("FAIL bp_cnt got=%0d want=%0d", beat_cnt, m_cnt); end
        n_checks++; if ({out_phase, out_b} !== exp_head()) begin
            n_fails++; $display("FAIL bp_head got=%h want=%h", {out_phase, out_b}, exp_head()); end
        held_b = out_b; held_ph = out_phase; first = exp_head();
        for (int i = 0; i < 3; i++) begin
            in_a = 4'($urandom_range(0, 15)); in_sum = 4'($urandom_range(0, 15));
            cycle();
            n_checks++; if (out_b !== first[3:0] || out_phase !== first[4] || out_valid !== 1'b1) begin
                n_fails++; $display("FAIL bp_stable cyc=%0d got v=%b b=%0d ph=%b want v=1 b=%0d ph=%b",
                                    i, out_valid, out_b, out_phase, held_b, held_ph); end
        end
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (out_valid !== 1'b1 || {out_phase, out_b} !== exp_head()) begin
                n_fails++; $display("FAIL drain_%0d got v=%b dat=%h want v=1 dat=%h", i, out_valid, {out_phase, out_b}, exp_head()); end
            cycle();
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL drain_empty got=%b want=0", out_valid); end
    endtask

    task automatic test_sync_accept();
        out_ready = 1;
        sync_i = 1; cycle(); sync_i = 0;      // phase -> 0 without a beat
        in_valid = 1; in_a = 4'd7; in_sum = 4'd9;
        cycle();                              // phase 0 beat, phase -> 1
        sync_i = 1; in_a = 4'd2; in_sum = 4'd11;
        cycle();                              // sync with accept: this beat is phase 0
        n_checks++; if (out_phase !== 1'b0 || out_b !== ref_b(4'd2, 4'd11, 1'b0)) begin
            n_fails++; $display("FAIL sync_beat got b=%0d ph=%b want b=%0d ph=0", out_b, out_phase, ref_b(4'd2, 4'd11, 1'b0)); end
        sync_i = 0; in_a = 4'd4; in_sum = 4'd1;
        cycle();
        n_checks++; if (out_phase !== 1'b1 || out_b !== ref_b(4'd4, 4'd1, 1'b1)) begin
            n_fails++; $display("FAIL post_sync_beat got b=%0d ph=%b want b=%0d ph=1", out_b, out_phase, ref_b(4'd4, 4'd1, 1'b1)); end
        in_valid = 0;
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sync_i    = ($urandom_range(0, 9) == 0);
            in_a      = 4'($urandom_range(0, 15));
            in_sum    = 4'($urandom_range(0, 15));
            cycle();
            n_checks++; if (in_ready !== m_ready()) begin n_fails++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", i, in_ready, m_ready()); end
            n_checks++; if (out_valid !== (m_q.size() > 0)) begin n_fails++; $display("FAIL rnd_out_valid cyc=%0d got=%b", i, out_valid); end
            n_checks++; if ({out_phase, out_b} !== exp_head()) begin
                n_fails++; $display("FAIL rnd_head cyc=%0d got=%h want=%h", i, {out_phase, out_b}, exp_head()); end
            n_checks++; if (beat_cnt !== m_cnt) begin n_fails++; $display("FAIL rnd_cnt cyc=%0d got=%0d want=%0d", i, beat_cnt, m_cnt); end
        end
        sync_i = 0; in_valid = 0;
    endtask

    task automatic test_reset_flush();
        out_ready = 0; in_valid = 1; in_a = 4'd1; in_sum = 4'd2;
        cycle(); cycle(); cycle();
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fails++; $display("FAIL flush_pre got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready); end
        rst_n = 0;
        cycle();
        rst_n = 1;
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
        n_checks++; if (beat_cnt !== 8'd0) begin n_fails++; $display("FAIL flush_cnt got=%0d want=0", beat_cnt); end
        cycle();
        n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL flush_wait_sync got=%b want=0", in_ready); end
        in_valid = 0;
    endtask

    task automatic test_cnt_wrap();
        sync_i = 1; cycle(); sync_i = 0;
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 256; i++) begin
            in_a = 4'($urandom_range(0, 15)); in_sum = 4'($urandom_range(0, 15));
            cycle();
            if (i == 254) begin
                n_checks++; if (beat_cnt !== 8'd255) begin n_fails++; $display("FAIL cnt_255 got=%0d want=255", beat_cnt); end
            end
        end
        in_valid = 0;
        n_checks++; if (beat_cnt !== 8'd0) begin n_fails++; $display("FAIL cnt_wrap got=%0d want=0", beat_cnt); end
        n_checks++; if ({out_phase, out_b} !== exp_head()) begin
            n_fails++; $display("FAIL cnt_last_beat got=%h want=%h", {out_phase, out_b}, exp_head()); end
    endtask

    initial begin
        test_reset();
        test_basic_decode();
        test_wrap();
        test_backpressure();
        test_sync_accept();
        test_random();
        test_reset_flush();
        test_cnt_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
